// File: rtl/delay_sequencer.sv
// rtl/delay_sequencer.sv - queues delay values and drives an external down-counter through load/settle/run/done
// Optional feature macro: DELAY_SEQ_ZERO_BYPASS_EN (zero delays skip the counter entirely).
module delay_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_value,
    output logic [WIDTH-1:0]         cnt_in,
    output logic                     cnt_latch,
    output logic                     cnt_dec,
    input  logic                     cnt_zero,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [WIDTH-1:0]   head;
    logic [WIDTH-1:0]   cur_value;
    logic               push;
    logic               pop;

    assign req_ready = (level != LEVEL_FULL);
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr];
    assign cnt_in    = cur_value;
    // Decrement stops combinationally on zero so the counter can never wrap.
    assign cnt_dec   = (state == ST_RUN) && !cnt_zero;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (level != '0) begin
                    pop = 1'b1;
`ifdef DELAY_SEQ_ZERO_BYPASS_EN
                    state_nxt = (head == '0) ? ST_DONE : ST_LOAD;
`else
                    state_nxt = ST_LOAD;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD:   state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_RUN;
            ST_RUN:    if (cnt_zero) state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= req_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_value <= '0;
            cnt_latch <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_latch <= (state_nxt == ST_LOAD);
            done      <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
            if (pop) begin
                cur_value <= head;
            end
        end
    end

endmodule

// File: tb/tb_delay_sequencer.sv
// tb/tb_delay_sequencer.sv - randomized self-checking bench with a schedule-level reference model
module tb_delay_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int MAXT  = 1024;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_value;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_latch;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             done;
    logic             busy;
    logic [2:0]       level;

    always #5 clock = ~clock;

    delay_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_value(req_value),
        .cnt_in(cnt_in),
        .cnt_latch(cnt_latch),
        .cnt_dec(cnt_dec),
        .cnt_zero(cnt_zero),
        .done(done),
        .busy(busy),
        .level(level)
    );

    // Behavioural down-counter with a non-zero stale power-up value and no reset.
    logic [WIDTH-1:0] cnt = 4'd7;
    always @(posedge clock) begin
        if (cnt_latch) cnt <= cnt_in;
        else if (cnt_dec) cnt <= cnt - 4'd1;
    end
    assign cnt_zero = (cnt == 4'd0);

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cyc[$];
    int acc_val[$];

    always @(posedge clock) begin
        if (req_valid && req_ready && !reset) begin
            acc_cyc.push_back(cyc);
            acc_val.push_back(int'(req_value));
        end
        cyc++;
    end

    logic tr_latch [MAXT];
    logic tr_dec   [MAXT];
    logic tr_done  [MAXT];
    logic tr_busy  [MAXT];
    logic tr_ready [MAXT];
    int   tr_level [MAXT];
    int   tr_cin   [MAXT];

    always @(negedge clock) begin
        #1;
        if (cyc >= 0 && cyc < MAXT) begin
            tr_latch[cyc] = cnt_latch;
            tr_dec[cyc]   = cnt_dec;
            tr_done[cyc]  = done;
            tr_busy[cyc]  = busy;
            tr_ready[cyc] = req_ready;
            tr_level[cyc] = int'(level);
            tr_cin[cyc]   = int'(cnt_in);
        end
    end

    logic ex_latch [MAXT];
    logic ex_dec   [MAXT];
    logic ex_done  [MAXT];
    logic ex_busy  [MAXT];
    int   ex_level [MAXT];
    int   ex_cin   [MAXT];
    int   m_last;
    int   first_bad;
    string sig_name [7] = '{"latch", "dec", "done", "busy", "level", "ready", "cnt_in"};

    // Schedule model: each request starts two cycles after acceptance or one cycle after the previous done.
    task automatic build_model();
        int prev;
        int first;
        int v;
        int lv;
        int pops[$];
        for (int t = 0; t < MAXT; t++) begin
            ex_latch[t] = 1'b0; ex_dec[t] = 1'b0; ex_done[t] = 1'b0;
            ex_busy[t] = 1'b0; ex_level[t] = 0; ex_cin[t] = 0;
        end
        prev   = -100;
        m_last = -1;
        for (int k = 0; k < acc_cyc.size(); k++) begin
            v     = acc_val[k];
            first = (acc_cyc[k] + 2 > prev + 1) ? acc_cyc[k] + 2 : prev + 1;
            pops.push_back(first);
`ifdef DELAY_SEQ_ZERO_BYPASS_EN
            if (v == 0) begin
                ex_busy[first] = 1'b1;
                ex_done[first] = 1'b1;
                prev = first;
                m_last = prev;
                continue;
            end
`endif
            ex_latch[first] = 1'b1;
            ex_cin[first]   = v;
            for (int t = first; t <= first + v + 3; t++) ex_busy[t] = 1'b1;
            for (int t = first + 2; t <= first + 1 + v; t++) ex_dec[t] = 1'b1;
            prev = first + v + 3;
            ex_done[prev] = 1'b1;
            m_last = prev;
        end
        for (int t = 0; t < MAXT; t++) begin
            lv = 0;
            foreach (acc_cyc[i]) if (acc_cyc[i] < t) lv++;
            foreach (pops[i]) if (pops[i] <= t) lv--;
            ex_level[t] = lv;
        end
    endtask

    function automatic int trace_err(input int sel, input int t_end);
        int errs = 0;
        logic bad;
        first_bad = -1;
        for (int t = 1; t < t_end; t++) begin
            case (sel)
                0: bad = (tr_latch[t] !== ex_latch[t]);
                1: bad = (tr_dec[t] !== ex_dec[t]);
                2: bad = (tr_done[t] !== ex_done[t]);
                3: bad = (tr_busy[t] !== ex_busy[t]);
                4: bad = (tr_level[t] !== ex_level[t]);
                5: bad = (tr_ready[t] !== (ex_level[t] < DEPTH));
                default: bad = ex_latch[t] && (tr_cin[t] !== ex_cin[t]);
            endcase
            if (bad) begin
                errs++;
                if (first_bad < 0) first_bad = t;
            end
        end
        return errs;
    endfunction

    task automatic begin_scn();
        @(negedge clock);
        acc_cyc.delete();
        acc_val.delete();
        cyc = 0;
    endtask

    task automatic send(input int v);
        int guard = 0;
        req_valid = 1'b1;
        req_value = WIDTH'(v);
        while (!req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL send_timeout: req_ready stayed %0b, required 1 within 200 cycles", req_ready);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic run_out(output int t_end);
        req_valid = 1'b0;
        build_model();
        t_end = (m_last < 0) ? 22 : m_last + 6;
        while (cyc < t_end) @(negedge clock);
        #2;
    endtask

    task automatic test_reset();
        int t_end;
        int e;
        reset = 1'b1;
        req_valid = 1'b0;
        req_value = '0;
        repeat (3) @(negedge clock);
        n_total++; if (cnt_latch !== 1'b0) $display("FAIL reset_latch: got %b want 0", cnt_latch); else n_pass++;
        n_total++; if (cnt_dec !== 1'b0) $display("FAIL reset_dec: got %b want 0", cnt_dec); else n_pass++;
        n_total++; if (cnt_in !== 4'd0) $display("FAIL reset_cnt_in: got %0d want 0", cnt_in); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
        reset = 1'b0;
        begin_scn();
        idle(20);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL idle_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        int t_end;
        int e;
        begin_scn();
        send(2);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL single_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
        n_total++; if (tr_latch[2] !== 1'b1 || tr_cin[2] !== 2) $display("FAIL single_load_c2: latch=%b cnt_in=%0d want 1/2", tr_latch[2], tr_cin[2]); else n_pass++;
        n_total++; if ({tr_dec[4], tr_dec[5], tr_dec[6]} !== 3'b110) $display("FAIL single_dec_4_6: got %b%b%b want 110", tr_dec[4], tr_dec[5], tr_dec[6]); else n_pass++;
        n_total++; if (tr_done[7] !== 1'b1) $display("FAIL single_done_c7: got %b want 1", tr_done[7]); else n_pass++;
        n_total++; if (cnt !== 4'd0) $display("FAIL single_counter_end: got %0d want 0", cnt); else n_pass++;
    endtask

    task automatic test_fill();
        int t_end;
        int e;
        int vals[6] = '{3, 1, 4, 1, 5, 2};
        int dq[$];
        logic saw_stall = 1'b0;
        begin_scn();
        foreach (vals[i]) send(vals[i]);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL fill_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
        for (int t = 1; t < t_end; t++) begin
            if (tr_done[t]) dq.push_back(t);
            if (tr_ready[t] === 1'b0) saw_stall = 1'b1;
        end
        n_total++; if (saw_stall !== 1'b1) $display("FAIL fill_ready_drop: saw req_ready low=%b want 1", saw_stall); else n_pass++;
        n_total++;
        if (dq.size() !== 6) $display("FAIL fill_done_count: got %0d want 6", dq.size());
        else n_pass++;
        for (int k = 1; k < dq.size() && k < 6; k++) begin
            n_total++;
            if (dq[k] - dq[k-1] !== vals[k] + 4) $display("FAIL fill_spacing_%0d: got %0d want %0d", k, dq[k] - dq[k-1], vals[k] + 4);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        int t_end;
        int e;
        int dec_cnt = 0;
`ifdef DELAY_SEQ_ZERO_BYPASS_EN
        int want_done = 2;
`else
        int want_done = 5;
`endif
        begin_scn();
        send(0);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL zero_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
        for (int t = 1; t < t_end; t++) if (tr_dec[t]) dec_cnt++;
        n_total++; if (tr_done[want_done] !== 1'b1) $display("FAIL zero_done_cycle: done at %0d was %b want 1", want_done, tr_done[want_done]); else n_pass++;
        n_total++; if (dec_cnt !== 0) $display("FAIL zero_no_dec: got %0d dec cycles want 0", dec_cnt); else n_pass++;
    endtask

    task automatic test_max();
        int t_end;
        int e;
        int dec_cnt = 0;
        begin_scn();
        send(15);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL max_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
        for (int t = 1; t < t_end; t++) if (tr_dec[t]) dec_cnt++;
        n_total++; if (dec_cnt !== 15) $display("FAIL max_dec_cycles: got %0d want 15", dec_cnt); else n_pass++;
        n_total++; if (cnt !== 4'd0) $display("FAIL max_no_wrap: counter %0d want 0", cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t_end;
        int e;
        logic saw_done = 1'b0;
        begin_scn();
        send(9);
        send(4);
        send(6);
        idle(1);
        while (cyc < 8) @(negedge clock);
        n_total++; if (cnt_dec !== 1'b1) $display("FAIL midrst_in_run: cnt_dec=%b want 1", cnt_dec); else n_pass++;
        #3 reset = 1'b1;
        #1;
        n_total++;
        if ({cnt_latch, cnt_dec, done, busy} !== 4'b0000 || level !== 3'd0 || cnt_in !== 4'd0 || req_ready !== 1'b1)
            $display("FAIL midrst_async: latch=%b dec=%b done=%b busy=%b level=%0d cnt_in=%0d ready=%b want 0/0/0/0/0/0/1",
                     cnt_latch, cnt_dec, done, busy, level, cnt_in, req_ready);
        else n_pass++;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        n_total++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done: saw done=%b want 0", saw_done); else n_pass++;
        n_total++; if (busy !== 1'b0 || level !== 3'd0) $display("FAIL midrst_flushed: busy=%b level=%0d want 0/0", busy, level); else n_pass++;
        begin_scn();
        send(3);
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL after_rst_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int t_end;
        int e;
        int gap;
        begin_scn();
        for (int k = 0; k < 20; k++) begin
            gap = int'($urandom_range(0, 4));
            if (gap > 2) idle(gap - 2);
            send(int'($urandom_range(0, 15)));
        end
        run_out(t_end);
        for (int s = 0; s < 7; s++) begin
            n_total++;
            e = trace_err(s, t_end);
            if (e !== 0) $display("FAIL random_%s: %0d bad cycles (first at %0d), required 0", sig_name[s], e, first_bad);
            else n_pass++;
        end
        n_total++; if (acc_cyc.size() !== 20) $display("FAIL random_accepts: got %0d want 20", acc_cyc.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_zero();
        test_max();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
